// File: rtl/pot_dot_sequencer.sv
// Streams (activation, PoT weight) terms through one shared pot_shift and accumulates
// the products into a saturating signed dot product with valid/ready on both sides.

// Weight code: MSB = negate, low bits = k; product = (data * 2^(OW-IW)) >>> k.
module pot_shift #(
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int OUTPUT_BIT_WIDTH = 20
) (
  input  logic [INPUT_BIT_WIDTH-1:0]  data,
  input  logic [WEIGHT_BIT_WIDTH-1:0] weight,
  output logic [OUTPUT_BIT_WIDTH-1:0] product
);
  localparam int FRAC = OUTPUT_BIT_WIDTH - INPUT_BIT_WIDTH;

  logic signed [OUTPUT_BIT_WIDTH-1:0] base, mag;

  always_comb begin
    base = {data, {FRAC{1'b0}}};
    mag  = base >>> weight[WEIGHT_BIT_WIDTH-2:0];
    product = mag;
    // Negating the most negative value clamps to the most positive one.
    if (weight[WEIGHT_BIT_WIDTH-1])
      product = (mag == {1'b1, {(OUTPUT_BIT_WIDTH-1){1'b0}}}) ?
                {1'b0, {(OUTPUT_BIT_WIDTH-1){1'b1}}} : -mag;
  end
endmodule

module pot_dot_sequencer #(
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int OUTPUT_BIT_WIDTH = 20,
  parameter int ACC_BIT_WIDTH    = 24,
  parameter int COUNT_BIT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INPUT_BIT_WIDTH-1:0]  in_data,
  input  logic [WEIGHT_BIT_WIDTH-1:0] in_weight,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_BIT_WIDTH-1:0]    out_data,
  output logic [COUNT_BIT_WIDTH-1:0]  out_count,
  output logic                        out_overflow
);
  localparam int OW = OUTPUT_BIT_WIDTH;
  localparam int AW = ACC_BIT_WIDTH;

  typedef enum logic [1:0] {ACCEPT, DRAIN, FULL} state_t;

  state_t state, state_nxt;
  logic started, accept, take, s1_valid, sat;
  logic [OW-1:0] prod, s1_prod;
  logic [AW-1:0] acc, acc_nxt;
  logic [AW:0]   sum;
  logic [COUNT_BIT_WIDTH-1:0] count;
  logic ovf;

  pot_shift #(
    .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH),
    .WEIGHT_BIT_WIDTH(WEIGHT_BIT_WIDTH),
    .OUTPUT_BIT_WIDTH(OUTPUT_BIT_WIDTH)
  ) u_shift (
    .data   (in_data),
    .weight (in_weight),
    .product(prod)
  );

  assign in_ready     = started && (state == ACCEPT);
  assign out_valid    = (state == FULL);
  assign accept       = in_valid && in_ready;
  assign take         = out_valid && out_ready;
  assign out_data     = acc;
  assign out_count    = count;
  assign out_overflow = ovf;

  // DRAIN leaves once S1 is empty, i.e. the last product has reached acc.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid) state_nxt = FULL;
      FULL:    if (out_ready) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  always_comb begin
    sum     = {acc[AW-1], acc} + {{(AW+1-OW){s1_prod[OW-1]}}, s1_prod};
    sat     = sum[AW] != sum[AW-1];
    acc_nxt = sum[AW-1:0];
    if (sat) acc_nxt = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCEPT;
      started  <= 1'b0;
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      acc      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      started  <= 1'b1;
      s1_valid <= accept;
      if (accept) s1_prod <= prod;
      if (accept && count != '1) count <= count + 1'b1;
      if (take) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else if (s1_valid) begin
        acc <= acc_nxt;
        ovf <= ovf | sat;
      end
    end
  end
endmodule

// File: tb/tb_pot_dot_sequencer.sv
// Randomized + directed bench for pot_dot_sequencer against a job-level arithmetic model.
module tb_pot_dot_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0, in_weight = '0;
  logic in_ready, out_valid, out_overflow;
  logic [23:0] out_data;
  logic [7:0] out_count;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  pot_dot_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Product as a real number scaled by 2^16: in * 2^-k, sign from weight MSB.
  function automatic int ref_product(input logic [3:0] d, input logic [3:0] w);
    int v;
    int k;
    v = $signed(d) * 65536;
    k = int'(w[2:0]);
    v = v >>> k;
    if (w[3]) v = -v;
    if (v > 524287) v = 524287;
    return v;
  endfunction

  // Job-level model: which cycle the result appears, and its value.
  bit     m_started, m_pending, m_ovf;
  longint m_acc;
  int     m_cnt, edge_n, valid_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_pending = 0; m_ovf = 0;
      m_acc = 0; m_cnt = 0; edge_n = 0; valid_edge = 0;
    end else begin
      bit ir, ov;
      ir = m_started && !m_pending;
      ov = m_pending && (edge_n >= valid_edge);
      edge_n++;
      if (ov && out_ready) begin
        m_pending = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else if (ir && in_valid) begin
        m_acc += ref_product(in_data, in_weight);
        if (m_acc > 8388607)  begin m_acc = 8388607;  m_ovf = 1; end
        if (m_acc < -8388608) begin m_acc = -8388608; m_ovf = 1; end
        if (m_cnt < 255) m_cnt++;
        if (in_last) begin m_pending = 1; valid_edge = edge_n + 2; end
      end
      m_started = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_overflow", out_overflow, 0);
    end else begin
      bit eir, eov;
      eir = m_started && !m_pending;
      eov = m_pending && (edge_n >= valid_edge);
      chk("in_ready", in_ready, eir);
      chk("out_valid", out_valid, eov);
      if (eov) begin
        chk("out_data", longint'($signed(out_data)), m_acc);
        chk("out_count", out_count, m_cnt);
        chk("out_overflow", out_overflow, m_ovf);
      end
    end
  end

  task automatic send(input int d, input int w, input bit last);
    @(negedge clk); #1;
    in_valid = 1; in_data = d[3:0]; in_weight = w[3:0]; in_last = last;
    for (int n = 0; n < 200 && !in_ready; n++) begin @(negedge clk); #1; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic take(input string name, input longint ed, input int ec, input int eo,
                      output int lat);
    @(negedge clk); #1;
    in_valid = 0; in_last = 0; out_ready = 1;
    lat = 0;
    while (!out_valid && lat < 300) begin @(negedge clk); #1; lat++; end
    if (!out_valid) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_data"}, longint'($signed(out_data)), ed);
      chk({name, "_count"}, out_count, ec);
      chk({name, "_ovf"}, out_overflow, eo);
    end
    @(posedge clk);
    @(negedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    int lat;
    bit rdy_prev, new_job, sat_mode;
    logic [3:0] sat_val;

    repeat (3) @(negedge clk);
    #1 rst_n = 1;

    // Mid-job reset discards partial work
    for (int i = 0; i < 3; i++) send(3, 0, 0);
    @(negedge clk); #1;
    in_valid = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    chk("midreset_data", out_data, 0);
    #1 rst_n = 1;
    send(1, 0, 1);
    take("reset_job", 65536, 1, 0, lat);

    // Back-to-back terms and result latency
    send(1, 0, 0); send(1, 0, 0); send(-3, 0, 1);
    take("b2b", -65536, 3, 0, lat);
    chk("b2b_latency", lat, 2);

    // Zero activations with shifted/negated weights
    send(0, 1, 0); send(0, 9, 1);
    take("zero", 0, 2, 0, lat);

    // Backpressure: held result, ignored input
    send(5, 2, 1);
    @(negedge clk); #1;
    in_valid = 1; in_data = 4'd1; in_weight = 4'd0; in_last = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    take("bp", 81920, 1, 0, lat);
    send(1, 0, 1);
    take("bp_next", 65536, 1, 0, lat);

    // Saturation boundary
    for (int i = 0; i < 16; i++) send(-8, 0, i == 15);
    take("sat16", -8388608, 16, 0, lat);
    for (int i = 0; i < 17; i++) send(-8, 0, i == 16);
    take("sat17", -8388608, 17, 1, lat);
    send(1, 0, 1);
    take("after_sat", 65536, 1, 0, lat);

    // Bubbles between terms
    for (int i = 0; i < 4; i++) begin
      send(2, 0, i == 3);
      @(negedge clk); #1; in_valid = 0;
    end
    take("bubble", 524288, 4, 0, lat);

    // Term counter saturation
    for (int i = 0; i < 258; i++) send(0, 0, i == 257);
    take("cnt_sat", 0, 255, 0, lat);

    // Random traffic with random backpressure
    rdy_prev = 0; new_job = 1; sat_mode = 0; sat_val = '0;
    @(negedge clk); #1; in_valid = 0; in_last = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (in_valid && rdy_prev && in_last) new_job = 1;
      if (!in_valid || rdy_prev) begin
        if (new_job) begin
          sat_mode = ($urandom_range(2) == 0);
          sat_val  = $urandom_range(1) ? 4'h8 : 4'h7;
          new_job  = 0;
        end
        if ($urandom_range(3) != 0) begin
          in_valid = 1;
          if (sat_mode) begin in_data = sat_val; in_weight = 4'h0; end
          else begin in_data = 4'($urandom); in_weight = 4'($urandom); end
          in_last = ($urandom_range(sat_mode ? 24 : 6) == 0);
        end else begin
          in_valid = 0;
          in_last = 0;
        end
      end
      out_ready = 1'($urandom_range(1));
      rdy_prev = in_ready;
    end
    @(negedge clk); #1;
    in_valid = 0; out_ready = 1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
